mult_job_sequencer: RTL and testbench
=====================================

Name: mult_job_sequencer

Overview:
Upstream/downstream job wrapper for the sequential shift-add multiplier (control + datapath).
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Launches one multiply at a time: drives operands plus a one-cycle start pulse, waits for the multiplier's done, captures the product.
- Presents the product on a valid/ready output stream. Decouples producers from the multiplier's variable, data-dependent latency.

Parameters:
WIDTH, 4, operand width; product is 2*WIDTH
FIFO_DEPTH, 4, operand FIFO entries; power of two, >= 2
CNT_WIDTH, 16, width of completed-job counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept (not full)
in_a  in  WIDTH  multiplicand
in_b  in  WIDTH  multiplier
mult_start  out  1  one-cycle start pulse to multiplier control
mult_a  out  WIDTH  multiplicand to datapath; stable from LAUNCH through CAPTURE
mult_b  out  WIDTH  multiplier to datapath; stable from LAUNCH through CAPTURE
mult_done  in  1  multiplier done (productDone)
mult_product  in  2*WIDTH  running-sum register of datapath
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_product  out  2*WIDTH  captured product
busy  out  1  FSM not IDLE or FIFO not empty
job_count  out  CNT_WIDTH  completed (accepted) results, wraps

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, FIFO empty, in_ready=1, mult_start=0, mult_a=mult_b=0, out_valid=0, out_product=0, busy=0, job_count=0.
- Reset mid-job aborts it: buffered and in-flight operands are discarded and no result is produced. The multiplier is reset by its own reset.
- Push when in_valid && in_ready. in_ready = !full, registered from occupancy.
- When full, no push that cycle even if a pop occurs; no same-cycle fall-through.
- FIFO occupancy counter is log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE, RESULT.
- IDLE: if FIFO non-empty, pop head into mult_a/mult_b registers, go LAUNCH. Otherwise stay.
- LAUNCH: mult_start=1 for exactly this cycle, go WAIT.
- WAIT: mult_start=0. On mult_done=1, go CAPTURE. mult_done is ignored in every other state.
- CAPTURE: the datapath's final shift lands at the end of the done cycle. Latch mult_product into out_product, go RESULT.
- RESULT: out_valid=1, out_product held stable.
  - On out_ready=1: job_count += 1 (wraps at 2^CNT_WIDTH), go IDLE.
  - out_valid drops the cycle after acceptance.
  - Backpressure holds RESULT indefinitely; FIFO keeps accepting until full.
- Minimum latency, push to out_valid:
  - Push edge ends cycle 0; IDLE pops in cycle 1; LAUNCH in cycle 2.
  - WAIT runs for the multiplier time; CAPTURE follows the done cycle; out_valid rises on the next cycle.
- Simultaneous push and pop in IDLE are both honoured; occupancy is unchanged.
- Product width is exactly 2*WIDTH, unsigned; no truncation.

Optional Feature:
MULT_ZERO_BYPASS_EN
- Defined: in IDLE, if the popped in_a==0 or in_b==0, skip LAUNCH/WAIT/CAPTURE. Load out_product=0 and go directly to RESULT. mult_start is not pulsed and job_count still counts.
- Undefined: every job goes through the multiplier.

Decomposition:
- Package mult_seq_pkg holds:
  - state encoding: IDLE=0, LAUNCH=1, WAIT=2, CAPTURE=3, RESULT=4, 3-bit;
  - localparams PROD_WIDTH=2*WIDTH and PTR_WIDTH=$clog2(FIFO_DEPTH).
- One sub-module, mult_op_fifo: synchronous FIFO of {a,b} with push/pop, full/empty and async active-low reset. The sequencer FSM lives in the top.

Test Plan:
- Reset then single job a=3, b=5, with a multiplier model asserting done 10 cycles after start, out_ready=1 -> one mult_start pulse, out_product=15, out_valid high 1 cycle, job_count=1.
- Push 4 pairs back-to-back with FIFO_DEPTH=4 while the first multiply is in WAIT -> in_ready low after the 4th push; results {a*b} emerge in push order; job_count=4.
- Hold out_ready=0 for 20 cycles in RESULT with product 0xE1 (15*15) -> out_valid and out_product stable throughout; no new mult_start until acceptance.
- Pulse mult_done while IDLE and RESULT -> ignored; no state change or capture.
- Assert rst_n=0 during WAIT with 2 entries queued -> all outputs return to reset values immediately, FIFO empty, no result emitted after release.
- With MULT_ZERO_BYPASS_EN: push a=0, b=9 -> no mult_start, out_product=0 valid 2 cycles after the pop; without the macro -> mult_start pulses and out_product=0.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and sizing helpers for the multiplier job sequencer.
package mult_seq_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int PROD_WIDTH     = 2 * DEF_WIDTH;
    localparam int PTR_WIDTH      = $clog2(DEF_FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RESULT  = 3'd4
    } state_t;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous operand-pair FIFO; DEPTH must be a power of two so the
// pointers wrap naturally.
module mult_op_fifo
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign a_o     = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
    assign b_o     = mem_q[rd_ptr_q][WIDTH-1:0];

    // NOTE: non-blocking assignments for every register so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {a_i, b_i};
    end

endmodule

// File: rtl/mult_job_sequencer.sv
// Job wrapper around the sequential shift-add multiplier: operand FIFO in,
// one multiply in flight, product out. Optional MULT_ZERO_BYPASS_EN.
module mult_job_sequencer
    import mult_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 mult_start,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic                 mult_done,
    input  logic [2*WIDTH-1:0]   mult_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] job_count
);

    localparam int PW = prod_width(WIDTH);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [PW-1:0]        prod_q, prod_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     head_a, head_b;
    logic                 fifo_full, fifo_empty, fifo_pop;

    mult_op_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .a_i     (in_a),
        .b_i     (in_b),
        .pop_i   (fifo_pop),
        .a_o     (head_a),
        .b_o     (head_b),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready    = !fifo_full;
    assign mult_a      = a_q;
    assign mult_b      = b_q;
    assign out_product = prod_q;
    assign job_count   = cnt_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        fifo_pop   = 1'b0;
        mult_start = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    a_d      = head_a;
                    b_d      = head_b;
`ifdef MULT_ZERO_BYPASS_EN
                    if (head_a == '0 || head_b == '0) begin
                        prod_d  = '0;
                        state_d = RESULT;
                    end else begin
                        state_d = LAUNCH;
                    end
`else
                    state_d  = LAUNCH;
`endif
                end
            end
            LAUNCH: begin
                mult_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (mult_done) state_d = CAPTURE;
            end
            CAPTURE: begin
                // The datapath's last shift settles at the end of the done cycle.
                prod_d  = mult_product;
                state_d = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Randomized scoreboard bench for mult_job_sequencer with a behavioural
// multiplier model (done after a chosen latency, product lands a cycle later).
module tb_mult_job_sequencer;

    localparam int W  = 4;
    localparam int PW = 2 * W;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [W-1:0]  in_a, in_b;
    logic          mult_start;
    logic [W-1:0]  mult_a, mult_b;
    logic          mult_done;
    logic [PW-1:0] mult_product;
    logic          out_valid, out_ready;
    logic [PW-1:0] out_product;
    logic          busy;
    logic [CW-1:0] job_count;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [PW-1:0] exp_q[$];
    logic [CW-1:0] exp_jobs = '0;
    int            start_cnt = 0;
    int            lat_fixed = 10;

    always #5 clk = ~clk;

    mult_job_sequencer #(
        .WIDTH      (W),
        .FIFO_DEPTH (4),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .busy         (busy),
        .job_count    (job_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiplier model: done some cycles after start; the running sum is
    // still wrong during the done cycle and correct only on the next one.
    initial begin
        logic [W-1:0] ma, mb;
        int remaining;
        bit pending, land;
        ma = '0; mb = '0; remaining = 0; pending = 0; land = 0;
        mult_done = 1'b0;
        mult_product = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 0; land = 0;
                mult_done = 1'b0;
                mult_product = '0;
                continue;
            end
            mult_done = 1'b0;
            if (land) begin
                land = 0;
                mult_product = PW'(ma) * PW'(mb);
                check("operand_a_stable", 32'(mult_a), 32'(ma));
                check("operand_b_stable", 32'(mult_b), 32'(mb));
            end else if (mult_start) begin
                start_cnt++;
                ma = mult_a; mb = mult_b;
                remaining = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 12));
                pending = 1;
                mult_product = '0;
            end else if (pending) begin
                remaining--;
                if (remaining == 0) begin
                    pending = 0;
                    land = 1;
                    mult_done = 1'b1;
                    mult_product = (PW'(ma) * PW'(mb)) ^ PW'(8'hA5);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                // Stray done while no multiply is running must be ignored.
                mult_done = 1'b1;
                mult_product = PW'($urandom);
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted result.
    initial begin
        logic          prev_valid, prev_acc, prev_start;
        logic [PW-1:0] prev_prod, e;
        prev_valid = 0; prev_acc = 0; prev_start = 0; prev_prod = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                exp_jobs = '0;
                prev_valid = 0; prev_acc = 0; prev_start = 0;
                continue;
            end
            check("job_count", 32'(job_count), 32'(exp_jobs));
            if (mult_start) check("start_pulse_width", 32'(prev_start), 32'd0);
            if (out_valid) begin
                if (prev_valid && !prev_acc)
                    check("product_hold", 32'(out_product), 32'(prev_prod));
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 32'd0);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    check("product", 32'(out_product), 32'(e));
                    exp_jobs = exp_jobs + 1'b1;
                end
            end
            prev_valid = out_valid;
            prev_acc   = out_valid && out_ready;
            prev_prod  = out_product;
            prev_start = mult_start;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("push_ready_timeout", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back(PW'(a) * PW'(b));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},    32'(in_ready),    32'd1);
        check({tag, "_mult_start"},  32'(mult_start),  32'd0);
        check({tag, "_mult_a"},      32'(mult_a),      32'd0);
        check({tag, "_mult_b"},      32'(mult_b),      32'd0);
        check({tag, "_out_valid"},   32'(out_valid),   32'd0);
        check({tag, "_out_product"}, 32'(out_product), 32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_job_count"},   32'(job_count),   32'd0);
    endtask

    initial begin
        int lat, s0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single job 3*5, done 10 cycles after start.
        lat_fixed = 10;
        s0 = start_cnt;
        push(4'd3, 4'd5);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("single_latency", 32'(lat), 32'd14);
        check("single_product", 32'(out_product), 32'd15);
        @(negedge clk);
        check("single_valid_drop", 32'(out_valid), 32'd0);
        check("single_job_count", 32'(job_count), 32'd1);
        check("single_start_pulses", 32'(start_cnt), 32'(s0 + 1));
        drain();

        // Fill the FIFO while the first job sits in WAIT.
        push(4'd1, 4'd2);
        lat = 0;
        while (!mult_start && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("fill_start_seen", 32'(mult_start), 32'd1);
        push(4'd7, 4'd9);
        push(4'd15, 4'd14);
        push(4'd0, 4'd5);
        push(4'd11, 4'd3);
        check("fill_in_ready_low", 32'(in_ready), 32'd0);
        drain();
        check("fill_job_count", 32'(job_count), 32'd6);

        // Backpressure for 20 cycles on 15*15.
        out_ready = 1'b0;
        push(4'd15, 4'd15);
        push(4'd2, 4'd3);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        s0 = start_cnt;
        repeat (20) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_product", 32'(out_product), 32'hE1);
        end
        check("bp_no_new_start", 32'(start_cnt), 32'(s0));
        out_ready = 1'b1;
        drain();

        // Reset during WAIT with two entries still queued.
        push(4'd5, 4'd6);
        push(4'd7, 4'd8);
        push(4'd9, 4'd4);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midjob_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (30) @(negedge clk);
        check("post_reset_no_start", 32'(start_cnt), 32'(s0));
        check("post_reset_busy", 32'(busy), 32'd0);
        push(4'd2, 4'd2);
        drain();

        // Randomized traffic with random latency and backpressure.
        lat_fixed = 0;
        for (int i = 0; i < 300; i++) begin
            in_a = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            in_b = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            if (in_valid && in_ready) exp_q.push_back(PW'(in_a) * PW'(in_b));
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Zero operand: bypassed or multiplied depending on the build.
        lat_fixed = 3;
        s0 = start_cnt;
        push(4'd0, 4'd9);
        drain();
`ifdef MULT_ZERO_BYPASS_EN
        check("zero_no_start", 32'(start_cnt), 32'(s0));
`else
        check("zero_one_start", 32'(start_cnt), 32'(s0 + 1));
`endif

        repeat (2) @(negedge clk);
        check("final_job_count", 32'(job_count), 32'(exp_jobs));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
